// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, command and HALT encodings for the MIPS execution controller.
package mips_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with enable and sync clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clr) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/exec_controller.sv
// exec_controller: gates PC write and pipeline enable for debug RUN/STEP/STOP,
// freezing the PC on HALT and draining in-flight instructions before reporting halted.
module exec_controller
    import mips_ctrl_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               NSTAGES   = 5,
    parameter int               CNT_BITS  = 32,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic [NBITS-1:0]    i_instr,
    output logic                o_pipe_en,
    output logic                o_pc_we,
    output logic                o_step_done,
    output logic                o_halted,
    output logic                o_busy,
    output logic [CNT_BITS-1:0] o_cycle_count
);
    localparam int DW = $clog2(NSTAGES) + 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(NSTAGES - 1);

    state_t        state, state_nx;
    logic [DW-1:0] drain_cnt, drain_nx;
    logic          halt_det, accept;

    assign halt_det    = i_instr == HALT_WORD;
    assign o_pipe_en   = state inside {RUN, STEP, DRAIN};
    assign o_pc_we     = o_pipe_en && !halt_det && state != DRAIN;
    assign o_cmd_ready = state inside {IDLE, RUN, HALTED};
    assign accept      = i_cmd_valid && o_cmd_ready;

    always_comb begin
        state_nx = state;
        drain_nx = drain_cnt;
        case (state)
            IDLE:   state_nx = !accept ? IDLE : i_cmd == CMD_RUN ? RUN : i_cmd == CMD_STEP ? STEP : IDLE;
            RUN: begin
                // HALT wins over any command offered in the same cycle; that command is still consumed
                if (halt_det) begin
                    state_nx = DRAIN;
                    drain_nx = DRAIN_LOAD;
                end else if (accept && i_cmd == CMD_STOP) state_nx = IDLE;
            end
            STEP: begin
                state_nx = halt_det ? DRAIN : IDLE;
                drain_nx = halt_det ? DRAIN_LOAD : drain_cnt;
            end
            DRAIN: begin
                // leave on the last drain cycle; a zero load still spends one cycle here
                drain_nx = drain_cnt - DW'(drain_cnt != '0);
                state_nx = drain_cnt <= DW'(1) ? HALTED : DRAIN;
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            o_step_done <= 1'b0;
            o_halted    <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nx;
            drain_cnt   <= drain_nx;
            o_step_done <= state == STEP && state_nx == IDLE;
            o_halted    <= state_nx == HALTED;
            o_busy      <= state_nx inside {RUN, STEP, DRAIN};
        end
    end

    sat_counter #(.W(CNT_BITS)) u_cycles (
        .clk   (i_clk),
        .clr   (i_reset),
        .en    (o_pipe_en),
        .count (o_cycle_count)
    );
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: directed vectors for exec_controller, plus a 4-bit counter
// instance and a single-stage instance sharing the same stimulus.
module tb_exec_controller;
    import mips_ctrl_pkg::*;

    localparam logic [31:0] NOP  = 32'h0000_0020;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, cmd_valid;
    logic [1:0]  cmd;
    logic [31:0] instr;
    logic        ready, pipe_en, pc_we, step_done, halted, busy;
    logic [31:0] count;
    logic        ready4, pipe_en4, pc_we4, step_done4, halted4, busy4;
    logic [3:0]  count4;
    logic        ready1, pipe_en1, pc_we1, step_done1, halted1, busy1;
    logic [31:0] count1;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    exec_controller dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(ready),
        .i_instr(instr), .o_pipe_en(pipe_en), .o_pc_we(pc_we), .o_step_done(step_done),
        .o_halted(halted), .o_busy(busy), .o_cycle_count(count)
    );

    exec_controller #(.CNT_BITS(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(ready4),
        .i_instr(instr), .o_pipe_en(pipe_en4), .o_pc_we(pc_we4), .o_step_done(step_done4),
        .o_halted(halted4), .o_busy(busy4), .o_cycle_count(count4)
    );

    exec_controller #(.NSTAGES(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(ready1),
        .i_instr(instr), .o_pipe_en(pipe_en1), .o_pc_we(pc_we1), .o_step_done(step_done1),
        .o_halted(halted1), .o_busy(busy1), .o_cycle_count(count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = CMD_NOP; instr = NOP;
        tick(); tick();
        check("rst_pipe", pipe_en, 0);
        check("rst_pcwe", pc_we, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_step", step_done, 0);
        check("rst_count", count, 0);
        check("rst_ready", ready, 1);
        rst = 1'b0;
        // plain run for 10 enabled cycles, then stop
        send(CMD_RUN);
        check("run_pipe", pipe_en, 1);
        check("run_pcwe", pc_we, 1);
        check("run_busy", busy, 1);
        check("run_count0", count, 0);
        repeat (10) tick();
        check("run10_count", count, 10);
        check("run10_count4", count4, 10);
        send(CMD_STOP);
        check("stop_pipe", pipe_en, 0);
        check("stop_busy", busy, 0);
        check("stop_count", count, 11);
        // stop after 4 cycles, hold, resume
        do_reset();
        send(CMD_RUN);
        repeat (3) tick();
        send(CMD_STOP);
        check("stop4_pipe", pipe_en, 0);
        check("stop4_count", count, 4);
        tick(); tick();
        check("idle_hold", count, 4);
        send(CMD_RUN);
        check("resume_count", count, 4);
        tick(); tick();
        check("resume_count2", count, 6);
        send(CMD_STEP);
        check("run_step_ign_busy", busy, 1);
        check("run_step_ign_done", step_done, 0);
        check("run_step_ign_cnt", count, 7);
        send(CMD_NOP);
        check("run_nop_busy", busy, 1);
        // HALT fetched on the 7th enabled cycle
        do_reset();
        send(CMD_RUN);
        repeat (6) tick();
        instr = HALT;
        #1;
        check("halt_pcwe", pc_we, 0);
        check("halt_pipe", pipe_en, 1);
        tick();
        instr = NOP;
        #1;
        check("drain_pcwe", pc_we, 0);
        check("drain_pipe", pipe_en, 1);
        check("drain_ready", ready, 0);
        check("drain_busy", busy, 1);
        check("drain_halted", halted, 0);
        check("drain1_halted_ns1", halted1, 0);
        tick();
        check("ns1_halted", halted1, 1);
        tick(); tick();
        check("drain4_halted", halted, 0);
        check("drain4_busy", busy, 1);
        tick();
        check("halted", halted, 1);
        check("halted_pipe", pipe_en, 0);
        check("halted_busy", busy, 0);
        check("halted_ready", ready, 1);
        check("halted_count", count, 11);
        send(CMD_RUN);
        check("halted_run_ign", halted, 1);
        check("halted_run_cnt", count, 11);
        do_reset();
        check("rst_halted_h", halted, 0);
        check("rst_halted_busy", busy, 0);
        check("rst_halted_pipe", pipe_en, 0);
        check("rst_halted_cnt", count, 0);
        // STOP coincident with HALT is discarded
        send(CMD_RUN);
        tick(); tick();
        instr = HALT; cmd_valid = 1'b1; cmd = CMD_STOP;
        tick();
        instr = NOP; cmd_valid = 1'b0;
        #1;
        check("haltstop_busy", busy, 1);
        check("haltstop_pipe", pipe_en, 1);
        check("haltstop_pcwe", pc_we, 0);
        repeat (3) tick();
        check("haltstop_h3", halted, 0);
        tick();
        check("haltstop_h4", halted, 1);
        // reset while draining
        do_reset();
        send(CMD_RUN);
        instr = HALT;
        tick();
        instr = NOP;
        tick();
        rst = 1'b1;
        tick();
        check("rst_drain_pipe", pipe_en, 0);
        check("rst_drain_busy", busy, 0);
        check("rst_drain_halted", halted, 0);
        check("rst_drain_cnt", count, 0);
        check("rst_drain_ready", ready, 1);
        rst = 1'b0;
        // three steps with STEP held valid; it must not be taken while stepping
        cmd_valid = 1'b1; cmd = CMD_STEP;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("step_pipe", pipe_en, 1);
            check("step_pcwe", pc_we, 1);
            check("step_ready", ready, 0);
            check("step_done_lo", step_done, 0);
            if (i == 2) cmd_valid = 1'b0;
            tick();
            check("step_done_hi", step_done, 1);
            check("step_idle_pipe", pipe_en, 0);
        end
        tick();
        check("step_pulse_end", step_done, 0);
        check("step_count", count, 3);
        // STEP that fetches HALT goes to drain, no step pulse
        send(CMD_STEP);
        instr = HALT;
        tick();
        instr = NOP;
        check("stephalt_busy", busy, 1);
        check("stephalt_done", step_done, 0);
        check("stephalt_pcwe", pc_we, 0);
        // 4-bit counter saturates
        do_reset();
        send(CMD_RUN);
        repeat (20) tick();
        check("sat_count4", count4, 15);
        check("sat_count32", count, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
